// File: rtl/speck_round_ctrl.sv
// Round/key-schedule sequencer for the SPECK datapath: key expansion, cipher rounds, output handshake.
// Optional SPECK_DECRYPT_EN honours the mode input (reverse round-key read order for decrypt).
module speck_round_ctrl #(
    parameter int unsigned ROUNDS = 22,
    parameter int unsigned CNT_W  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             key_new,
    input  logic             mode,
    input  logic             out_ready,
    output logic             ready,
    output logic             busy,
    output logic             key_ld,
    output logic             pt_ld,
    output logic             ks_en,
    output logic             rk_wr,
    output logic             rk_rd,
    output logic [CNT_W-1:0] rk_addr,
    output logic             rnd_en,
    output logic [CNT_W-1:0] rnd_idx,
    output logic             out_valid
);

    localparam logic [CNT_W-1:0] Rounds  = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] One     = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StKexp = 3'd2,
        StRun  = 3'd3,
        StDone = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_ok_q, key_ok_d;
    logic             mode_q, mode_d;
    logic             key_new_q, key_new_d;
    logic             mode_eff;

    logic             ready_d, busy_d, key_ld_d, pt_ld_d, ks_en_d, rk_wr_d, rk_rd_d;
    logic             rnd_en_d, out_valid_d;
    logic [CNT_W-1:0] rk_addr_d, rnd_idx_d;

`ifdef SPECK_DECRYPT_EN
    assign mode_eff = mode;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign mode_eff    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_ok_d  = key_ok_q;
        mode_d    = mode_q;
        key_new_d = key_new_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    mode_d    = mode_eff;
                    key_new_d = key_new || !key_ok_q;
                    cnt_d     = '0;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = key_new_q ? StKexp : StRun;
            end
            StKexp: begin
                if (cnt_q >= LastIdx) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    key_ok_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            StRun: begin
                if (cnt_q >= Rounds) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered copy matches the state.
    always_comb begin
        ready_d     = 1'b0;
        busy_d      = 1'b0;
        key_ld_d    = 1'b0;
        pt_ld_d     = 1'b0;
        ks_en_d     = 1'b0;
        rk_wr_d     = 1'b0;
        rk_rd_d     = 1'b0;
        rk_addr_d   = '0;
        rnd_en_d    = 1'b0;
        rnd_idx_d   = '0;
        out_valid_d = 1'b0;
        case (state_d)
            StIdle: ready_d = 1'b1;
            StLoad: begin
                busy_d   = 1'b1;
                pt_ld_d  = 1'b1;
                key_ld_d = key_new_d;
            end
            StKexp: begin
                busy_d    = 1'b1;
                rk_wr_d   = 1'b1;
                rk_addr_d = cnt_d;
                ks_en_d   = (cnt_d != LastIdx);
            end
            StRun: begin
                busy_d = 1'b1;
                if (cnt_d < Rounds) begin
                    rk_rd_d   = 1'b1;
                    rk_addr_d = mode_d ? (LastIdx - cnt_d) : cnt_d;
                end else begin
                    // Final cycle: hold the last address issued.
                    rk_addr_d = mode_d ? '0 : LastIdx;
                end
                if (cnt_d != '0) begin
                    rnd_en_d  = 1'b1;
                    rnd_idx_d = cnt_d - One;
                end
            end
            StDone: begin
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            key_ok_q  <= 1'b0;
            mode_q    <= 1'b0;
            key_new_q <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            key_ld    <= 1'b0;
            pt_ld     <= 1'b0;
            ks_en     <= 1'b0;
            rk_wr     <= 1'b0;
            rk_rd     <= 1'b0;
            rk_addr   <= '0;
            rnd_en    <= 1'b0;
            rnd_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_ok_q  <= key_ok_d;
            mode_q    <= mode_d;
            key_new_q <= key_new_d;
            ready     <= ready_d;
            busy      <= busy_d;
            key_ld    <= key_ld_d;
            pt_ld     <= pt_ld_d;
            ks_en     <= ks_en_d;
            rk_wr     <= rk_wr_d;
            rk_rd     <= rk_rd_d;
            rk_addr   <= rk_addr_d;
            rnd_en    <= rnd_en_d;
            rnd_idx   <= rnd_idx_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_speck_round_ctrl.sv
// Directed self-checking bench for speck_round_ctrl at ROUNDS=22, CNT_W=5.
module tb_speck_round_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       key_new;
    logic       mode;
    logic       out_ready;
    logic       ready, busy, key_ld, pt_ld, ks_en, rk_wr, rk_rd, rnd_en, out_valid;
    logic [4:0] rk_addr, rnd_idx;
    logic [18:0] obs;

    int n_checks;
    int n_fail;

`ifdef SPECK_DECRYPT_EN
    localparam bit DecOn = 1'b1;
`else
    localparam bit DecOn = 1'b0;
`endif

    speck_round_ctrl #(.ROUNDS(22), .CNT_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .key_new   (key_new),
        .mode      (mode),
        .out_ready (out_ready),
        .ready     (ready),
        .busy      (busy),
        .key_ld    (key_ld),
        .pt_ld     (pt_ld),
        .ks_en     (ks_en),
        .rk_wr     (rk_wr),
        .rk_rd     (rk_rd),
        .rk_addr   (rk_addr),
        .rnd_en    (rnd_en),
        .rnd_idx   (rnd_idx),
        .out_valid (out_valid)
    );

    assign obs = {ready, busy, key_ld, pt_ld, ks_en, rk_wr, rk_rd, rk_addr, rnd_en, rnd_idx,
                  out_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] vec(bit rdy, bit bsy, bit kl, bit pl, bit ks, bit wr, bit rd,
                                        logic [4:0] addr, bit en, logic [4:0] idx, bit ov);
        return {rdy, bsy, kl, pl, ks, wr, rd, addr, en, idx, ov};
    endfunction

    localparam logic [18:0] IdleVec = 19'h40000;
    localparam logic [18:0] DoneVec = 19'h20001;

    // Expected outputs j cycles after the accepting edge (j=0 is the LOAD cycle).
    function automatic logic [18:0] sched(int j, bit kx, bit dec);
        int base;
        int c;
        base = kx ? 23 : 1;
        if (j == 0) return vec(0, 1, kx, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0);
        if (kx && j <= 22) return vec(0, 1, 0, 0, (j - 1) < 21, 1, 0, 5'(j - 1), 0, 5'd0, 0);
        if (j <= base + 22) begin
            c = j - base;
            if (c < 22)
                return vec(0, 1, 0, 0, 0, 0, 1, dec ? 5'(21 - c) : 5'(c), c >= 1,
                           c >= 1 ? 5'(c - 1) : 5'd0, 0);
            return vec(0, 1, 0, 0, 0, 0, 0, dec ? 5'd0 : 5'd21, 1, 5'd21, 0);
        end
        return DoneVec;
    endfunction

    task automatic run_block(input bit kn, input bit md, input bit kx, input int hold,
                             input string name);
        bit dec;
        int last;
        dec  = md & DecOn;
        last = (kx ? 23 : 1) + 23;
        @(negedge clk);
        n_checks++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL %s_idle got=%h exp=%h", name, obs, IdleVec);
        end
        start = 1'b1; key_new = kn; mode = md;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; key_new = 1'b0; mode = 1'b0;
        for (int j = 0; j <= last; j++) begin
            if (j > 0) @(negedge clk);
            n_checks++;
            if (obs !== sched(j, kx, dec)) begin
                n_fail++;
                $display("FAIL %s_seq j=%0d got=%h exp=%h", name, j, obs, sched(j, kx, dec));
            end
        end
        for (int h = 0; h < hold; h++) begin
            start = h[0];
            @(negedge clk);
            n_checks++;
            if (obs !== DoneVec) begin
                n_fail++;
                $display("FAIL %s_hold h=%0d got=%h exp=%h", name, h, obs, DoneVec);
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL %s_release got=%h exp=%h", name, obs, IdleVec);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start = 1'b0; key_new = 1'b0; mode = 1'b0; out_ready = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL reset_values got=%h exp=%h", obs, IdleVec);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", obs, IdleVec);
        end
    endtask

    task automatic test_expand();
        run_block(1'b1, 1'b0, 1'b1, 0, "expand");
    endtask

    task automatic test_key_reuse();
        run_block(1'b0, 1'b0, 1'b0, 0, "reuse");
    endtask

    task automatic test_decrypt();
        run_block(1'b0, 1'b1, 1'b0, 0, "decrypt");
    endtask

    task automatic test_reset_forces_expansion();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_block(1'b0, 1'b0, 1'b1, 0, "forced_exp");
    endtask

    task automatic test_done_hold();
        run_block(1'b0, 1'b0, 1'b0, 10, "done_hold");
    endtask

    task automatic test_reset_mid_kexp();
        @(negedge clk);
        start = 1'b1; key_new = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; key_new = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (obs !== sched(8, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_kexp7 got=%h exp=%h", obs, sched(8, 1'b1, 1'b0));
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL abort_async got=%h exp=%h", obs, IdleVec);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_block(1'b0, 1'b0, 1'b1, 0, "post_abort");
    endtask

    task automatic test_back_to_back();
        int  hs;
        int  acc;
        int  acc_cyc;
        bit  prev_ready;
        bit  prev_hs;
        @(negedge clk);
        hs = 0; acc = 0; acc_cyc = 0; prev_ready = ready; prev_hs = 1'b0;
        start = 1'b1; key_new = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && hs < 3; cyc++) begin
            @(negedge clk);
            if (prev_hs) begin
                n_checks++;
                if (!(ready === 1'b1 && pt_ld === 1'b0 && out_valid === 1'b0)) begin
                    n_fail++;
                    $display("FAIL b2b_after_hs got=%h exp=%h", obs, IdleVec);
                end
            end
            if (pt_ld === 1'b1) begin
                acc++;
                acc_cyc = cyc;
                n_checks++;
                if (prev_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_accept_not_idle got=%b exp=1", prev_ready);
                end
            end
            prev_hs = 1'b0;
            if (out_valid === 1'b1) begin
                hs++;
                prev_hs = 1'b1;
                n_checks++;
                if (cyc - acc_cyc !== 24 || acc !== hs) begin
                    n_fail++;
                    $display("FAIL b2b_block got_lat=%0d exp_lat=24 got_acc=%0d exp_acc=%0d",
                             cyc - acc_cyc, acc, hs);
                end
                if (hs == 3) start = 1'b0;
            end
            prev_ready = ready;
        end
        n_checks++;
        if (hs != 3) begin
            n_fail++;
            $display("FAIL b2b_timeout got=%0d exp=3", hs);
        end
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== IdleVec) begin
            n_fail++;
            $display("FAIL b2b_final got=%h exp=%h", obs, IdleVec);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_expand();
        test_key_reuse();
        test_decrypt();
        test_reset_forces_expansion();
        test_done_hold();
        test_reset_mid_kexp();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
